// File: rtl/cnt_bcd_modn_pkg.sv
// cnt_bcd_modn_pkg
// Shared definitions for the BCD modulo counter family. This package holds the
// BCD digit width and digit limit, and the standard digital-clock range presets
// (seconds/minutes, 24-hour, 12-hour). It also provides the operation encoding
// used by the counter's priority decode, and helpers that split a decimal value
// into its tens and ones BCD digits.
package cnt_bcd_modn_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_t;

    localparam bcd_t DIGIT_MAX = 4'd9;

    // Range presets for the usual clock stages.
    localparam int SEC_MIN_MAX_MIN = 0;
    localparam int SEC_MIN_MAX_MAX = 59;
    localparam int HOUR24_MIN      = 0;
    localparam int HOUR24_MAX      = 23;
    localparam int HOUR12_MIN      = 1;
    localparam int HOUR12_MAX      = 12;

    // What the counter does on the coming edge, after priority resolution.
    typedef enum logic [2:0] {
        OP_HOLD   = 3'd0,
        OP_LOAD   = 3'd1,
        OP_SET_UP = 3'd2,
        OP_SET_DN = 3'd3,
        OP_COUNT  = 3'd4
    } op_e;

    function automatic bcd_t tens_of(input int value);
        return bcd_t'((value / 10) % 10);
    endfunction

    function automatic bcd_t ones_of(input int value);
        return bcd_t'(value % 10);
    endfunction

endpackage

// File: rtl/cnt_bcd_modn_bcd_digit_updown.sv
// bcd_digit_updown
// This block steps a single BCD digit up or down. The upward step wraps from the
// programmable limit to 0, and the downward step wraps from 0 to the limit.
// wrap_o flags that the step wrapped, and acts as the carry or borrow into the
// next digit. The block is purely combinational; the owner keeps the register.
//
// Ports
//   digit_i  in  4  current digit value
//   lim_i    in  4  highest digit value before wrap (normally 9)
//   up_i     in  1  request an upward step
//   dn_i     in  1  request a downward step (ignored when up_i is set)
//   digit_o  out 4  stepped digit value (digit_i when no step requested)
//   wrap_o   out 1  step wrapped: carry when stepping up, borrow when down
module bcd_digit_updown
    import cnt_bcd_modn_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    input  logic [DIGIT_W-1:0] lim_i,
    input  logic               up_i,
    input  logic               dn_i,
    output logic [DIGIT_W-1:0] digit_o,
    output logic               wrap_o
);

    always_comb begin
        digit_o = digit_i;
        wrap_o  = 1'b0;
        if (up_i) begin
            // >= rather than == so an out-of-range digit still recovers to 0.
            if (digit_i >= lim_i) begin
                digit_o = '0;
                wrap_o  = 1'b1;
            end else begin
                digit_o = digit_i + 4'd1;
            end
        end else if (dn_i) begin
            if (digit_i == '0) begin
                digit_o = lim_i;
                wrap_o  = 1'b1;
            end else begin
                digit_o = digit_i - 4'd1;
            end
        end
    end

endmodule

// File: rtl/cnt_bcd_modn.sv
// cnt_bcd_modn
// This is a two-digit BCD modulo counter for the digital-clock datapath. Its
// count range is MIN_VAL..MAX_VAL. The counter advances on a one-cycle enable
// from the previous stage, and it emits a one-cycle carry when it wraps. In
// setting mode, inc and dec pulses adjust the value and carry is suppressed.
// A parallel load is accepted only when both digits and the value are valid.
//
// Ports
//   clk        in  1  system clock
//   CLR_n      in  1  synchronous reset, active HIGH despite the name
//   ce         in  1  count enable / carry-in from the lower stage
//   isSetting  in  1  setting mode level
//   inc, dec   in  1  setting adjust pulses
//   load       in  1  parallel-load strobe
//   load_tens  in  4  BCD tens digit to load
//   load_ones  in  4  BCD ones digit to load
//   tens, ones out 4  registered BCD value
//   carry      out 1  registered wrap pulse to the next stage
//   at_max     out 1  value equals MAX_VAL
//   load_err   out 1  registered pulse: last load was rejected
module cnt_bcd_modn
    import cnt_bcd_modn_pkg::*;
#(
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 59
) (
    input  logic               clk,
    input  logic               CLR_n,
    input  logic               ce,
    input  logic               isSetting,
    input  logic               inc,
    input  logic               dec,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_tens,
    input  logic [DIGIT_W-1:0] load_ones,
    output logic [DIGIT_W-1:0] tens,
    output logic [DIGIT_W-1:0] ones,
    output logic               carry,
    output logic               at_max,
    output logic               load_err
);

    if (MIN_VAL < 0 || MIN_VAL >= MAX_VAL || MAX_VAL > 99) begin : g_bad_range
        $error("cnt_bcd_modn: need 0 <= MIN_VAL < MAX_VAL <= 99");
    end

    localparam bcd_t MIN_TENS = tens_of(MIN_VAL);
    localparam bcd_t MIN_ONES = ones_of(MIN_VAL);
    localparam bcd_t MAX_TENS = tens_of(MAX_VAL);
    localparam bcd_t MAX_ONES = ones_of(MAX_VAL);
    localparam logic [8:0] MIN_V9 = 9'(MIN_VAL);
    localparam logic [8:0] MAX_V9 = 9'(MAX_VAL);

    bcd_t tens_q, tens_d;
    bcd_t ones_q, ones_d;
    logic carry_q, carry_d;
    logic load_err_q, load_err_d;

    op_e  op;
    logic step_up, step_dn;
    logic at_max_w, at_min_w;
    bcd_t ones_step, tens_step;
    logic ones_wrap, tens_wrap;
    logic [8:0] load_val;
    logic load_ok;

    // Priority: load > setting > count. Reset is applied in the register.
    always_comb begin
        op = OP_HOLD;
        if (load) begin
            op = OP_LOAD;
        end else if (isSetting) begin
            // ce is deliberately not looked at while setting.
            if (inc && !dec) begin
                op = OP_SET_UP;
            end else if (dec && !inc) begin
                op = OP_SET_DN;
            end
        end else if (ce) begin
            op = OP_COUNT;
        end
    end

    assign step_up = (op == OP_SET_UP) || (op == OP_COUNT);
    assign step_dn = (op == OP_SET_DN);

    assign at_max_w = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);
    assign at_min_w = (tens_q == MIN_TENS) && (ones_q == MIN_ONES);

    bcd_digit_updown u_ones (
        .digit_i (ones_q),
        .lim_i   (DIGIT_MAX),
        .up_i    (step_up),
        .dn_i    (step_dn),
        .digit_o (ones_step),
        .wrap_o  (ones_wrap)
    );

    // Tens only moves when the ones digit wrapped in the same direction.
    bcd_digit_updown u_tens (
        .digit_i (tens_q),
        .lim_i   (DIGIT_MAX),
        .up_i    (step_up && ones_wrap),
        .dn_i    (step_dn && ones_wrap),
        .digit_o (tens_step),
        .wrap_o  (tens_wrap)
    );

    // Widened to 9 bits: the worst case with invalid digits is 15*10+15.
    assign load_val = (9'(load_tens) * 9'd10) + 9'(load_ones);

    // The lower bound is written as v+1 > MIN so it stays meaningful when MIN_VAL is 0.
    assign load_ok = (load_tens <= DIGIT_MAX) && (load_ones <= DIGIT_MAX)
                  && ((load_val + 9'd1) > MIN_V9) && (load_val <= MAX_V9);

    always_comb begin
        tens_d     = tens_q;
        ones_d     = ones_q;
        carry_d    = 1'b0;
        load_err_d = 1'b0;
        case (op)
            OP_LOAD: begin
                if (load_ok) begin
                    tens_d = load_tens;
                    ones_d = load_ones;
                end else begin
                    load_err_d = 1'b1;
                end
            end
            OP_SET_UP, OP_COUNT: begin
                // tens_wrap covers a value past 99, which the range check
                // forbids; it only lets a corrupted value recover.
                if (at_max_w || tens_wrap) begin
                    tens_d  = MIN_TENS;
                    ones_d  = MIN_ONES;
                    carry_d = (op == OP_COUNT);
                end else begin
                    tens_d = tens_step;
                    ones_d = ones_step;
                end
            end
            OP_SET_DN: begin
                if (at_min_w || tens_wrap) begin
                    tens_d = MAX_TENS;
                    ones_d = MAX_ONES;
                end else begin
                    tens_d = tens_step;
                    ones_d = ones_step;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (CLR_n) begin
            tens_q     <= MIN_TENS;
            ones_q     <= MIN_ONES;
            carry_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            carry_q    <= carry_d;
            load_err_q <= load_err_d;
        end
    end

    assign tens     = tens_q;
    assign ones     = ones_q;
    assign carry    = carry_q;
    assign at_max   = at_max_w;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_cnt_bcd_modn.sv
module tb_cnt_bcd_modn;

    logic       clk = 1'b0;
    logic       CLR_n = 1'b0;
    logic       ce = 1'b0;
    logic       isSetting = 1'b0;
    logic       inc = 1'b0;
    logic       dec = 1'b0;
    logic       load = 1'b0;
    logic       load_m = 1'b0;
    logic [3:0] load_tens = 4'd0;
    logic [3:0] load_ones = 4'd0;

    logic [3:0] s_tens, s_ones, h_tens, h_ones, m_tens, m_ones;
    logic       s_carry, s_at_max, s_err;
    logic       h_carry, h_at_max, h_err;
    logic       m_carry, m_at_max, m_err;

    always #5 clk = ~clk;

    // Seconds stage and 12-hour stage share all stimulus.
    cnt_bcd_modn #(.MIN_VAL(0), .MAX_VAL(59)) dut_sec (
        .clk(clk), .CLR_n(CLR_n), .ce(ce), .isSetting(isSetting), .inc(inc), .dec(dec),
        .load(load), .load_tens(load_tens), .load_ones(load_ones),
        .tens(s_tens), .ones(s_ones), .carry(s_carry), .at_max(s_at_max), .load_err(s_err)
    );

    cnt_bcd_modn #(.MIN_VAL(1), .MAX_VAL(12)) dut_h12 (
        .clk(clk), .CLR_n(CLR_n), .ce(ce), .isSetting(isSetting), .inc(inc), .dec(dec),
        .load(load), .load_tens(load_tens), .load_ones(load_ones),
        .tens(h_tens), .ones(h_ones), .carry(h_carry), .at_max(h_at_max), .load_err(h_err)
    );

    // Minutes stage chained from the seconds stage carry.
    cnt_bcd_modn #(.MIN_VAL(0), .MAX_VAL(59)) dut_min (
        .clk(clk), .CLR_n(CLR_n), .ce(s_carry), .isSetting(1'b0), .inc(1'b0), .dec(1'b0),
        .load(load_m), .load_tens(load_tens), .load_ones(load_ones),
        .tens(m_tens), .ones(m_ones), .carry(m_carry), .at_max(m_at_max), .load_err(m_err)
    );

    typedef struct packed {
        logic [7:0] v;
        logic       carry;
        logic       at_max;
        logic       err;
    } exp_t;

    typedef struct packed {
        exp_t s;
        exp_t h;
        exp_t m;
    } rec_t;

    rec_t sb[$];
    rec_t mon_r;
    int   checks = 0;
    int   failures = 0;

    // Model state: decimal value of each stage plus the seconds carry that feeds minutes.
    int   v_s = 0, v_h = 1, v_m = 0;
    bit   c_s = 1'b0;

    function automatic exp_t model(input int mn, input int mx, input int v,
                                   input bit clr_i, input bit ld_i,
                                   input logic [3:0] lt, input logic [3:0] lo,
                                   input bit set_i, input bit inc_i, input bit dec_i,
                                   input bit ce_i);
        exp_t e;
        int   nv;
        int   lv;
        nv = v;
        e.carry = 1'b0;
        e.err   = 1'b0;
        lv = int'(lt) * 10 + int'(lo);
        if (clr_i) begin
            nv = mn;
        end else if (ld_i) begin
            if (lt <= 9 && lo <= 9 && lv >= mn && lv <= mx) nv = lv;
            else e.err = 1'b1;
        end else if (set_i) begin
            if (inc_i && !dec_i) nv = (v == mx) ? mn : v + 1;
            else if (dec_i && !inc_i) nv = (v == mn) ? mx : v - 1;
        end else if (ce_i) begin
            if (v == mx) begin
                nv = mn;
                e.carry = 1'b1;
            end else begin
                nv = v + 1;
            end
        end
        e.v = 8'(nv);
        e.at_max = (nv == mx);
        return e;
    endfunction

    task automatic step(input bit clr_i, input bit ld_i, input logic [3:0] lt, input logic [3:0] lo,
                        input bit set_i, input bit inc_i, input bit dec_i, input bit ce_i,
                        input bit ldm_i);
        rec_t r;
        @(negedge clk);
        CLR_n = clr_i; load = ld_i; load_tens = lt; load_ones = lo;
        isSetting = set_i; inc = inc_i; dec = dec_i; ce = ce_i; load_m = ldm_i;
        r.m = model(0, 59, v_m, clr_i, ldm_i, lt, lo, 1'b0, 1'b0, 1'b0, c_s);
        r.s = model(0, 59, v_s, clr_i, ld_i, lt, lo, set_i, inc_i, dec_i, ce_i);
        r.h = model(1, 12, v_h, clr_i, ld_i, lt, lo, set_i, inc_i, dec_i, ce_i);
        v_m = int'(r.m.v);
        v_s = int'(r.s.v);
        v_h = int'(r.h.v);
        c_s = r.s.carry;
        sb.push_back(r);
    endtask

    task automatic idle();
        step(0, 0, 4'd0, 4'd0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input exp_t e, input logic [3:0] t, input logic [3:0] o,
                       input logic c, input logic a, input logic er);
        logic [3:0] et, eo;
        et = 4'(int'(e.v) / 10);
        eo = 4'(int'(e.v) % 10);
        checks++;
        if (t !== et || o !== eo || c !== e.carry || a !== e.at_max || er !== e.err) begin
            failures++;
            $display("FAIL %s @%0t: got tens=%0d ones=%0d carry=%b at_max=%b load_err=%b, expected tens=%0d ones=%0d carry=%b at_max=%b load_err=%b",
                     name, $time, t, o, c, a, er, et, eo, e.carry, e.at_max, e.err);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_r = sb.pop_front();
            chk("sec", mon_r.s, s_tens, s_ones, s_carry, s_at_max, s_err);
            chk("h12", mon_r.h, h_tens, h_ones, h_carry, h_at_max, h_err);
            chk("min", mon_r.m, m_tens, m_ones, m_carry, m_at_max, m_err);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset.
        step(1, 0, 4'd0, 4'd0, 0, 0, 0, 0, 0);
        step(1, 0, 4'd0, 4'd0, 0, 0, 0, 0, 0);
        // 60 back-to-back ce pulses: seconds full lap, 12-hour stage wraps several times.
        for (int i = 0; i < 60; i++) step(0, 0, 4'd0, 4'd0, 0, 0, 0, 1, 0);
        idle();
        idle();

        // Setting mode at 59: ce+inc wraps to 00 with no carry, dec back, inc+dec holds.
        step(0, 1, 4'd5, 4'd9, 0, 0, 0, 0, 0);
        step(0, 0, 4'd0, 4'd0, 1, 1, 0, 1, 0);
        step(0, 0, 4'd0, 4'd0, 1, 0, 1, 0, 0);
        step(0, 0, 4'd0, 4'd0, 1, 1, 1, 0, 0);
        step(0, 0, 4'd0, 4'd0, 1, 0, 0, 1, 0);
        step(0, 0, 4'd0, 4'd0, 0, 0, 0, 0, 0);

        // Load checks: 60 rejected, 45 accepted, ones=A rejected, 12 valid for both.
        step(0, 1, 4'd6, 4'd0, 0, 0, 0, 0, 0);
        step(0, 1, 4'd4, 4'd5, 0, 0, 0, 0, 0);
        step(0, 1, 4'd0, 4'd10, 0, 0, 0, 0, 0);
        step(0, 1, 4'd1, 4'd2, 0, 0, 0, 0, 0);
        step(0, 1, 4'd0, 4'd0, 0, 0, 0, 0, 0);
        idle();

        // Reset beats ce at MAX and beats load.
        step(0, 1, 4'd5, 4'd9, 0, 0, 0, 0, 0);
        step(1, 0, 4'd0, 4'd0, 0, 0, 0, 1, 0);
        step(1, 1, 4'd3, 4'd3, 0, 0, 0, 0, 1);
        idle();

        // Chain 59:59 -> 00:00, minutes carry one cycle after seconds carry.
        step(0, 1, 4'd5, 4'd9, 0, 0, 0, 0, 1);
        step(0, 0, 4'd0, 4'd0, 0, 0, 0, 1, 0);
        idle();
        idle();
        idle();

        // Randomized traffic.
        begin
            bit set_lvl;
            set_lvl = 1'b0;
            for (int i = 0; i < 500; i++) begin
                bit r_clr, r_ld, r_ldm, r_inc, r_dec, r_ce;
                logic [3:0] r_lt, r_lo;
                if ($urandom_range(0, 19) == 0) set_lvl = ~set_lvl;
                r_clr = ($urandom_range(0, 59) == 0);
                r_ld  = ($urandom_range(0, 11) == 0);
                r_ldm = ($urandom_range(0, 24) == 0);
                r_lt  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 5));
                r_lo  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
                r_inc = ($urandom_range(0, 2) == 0);
                r_dec = ($urandom_range(0, 2) == 0);
                r_ce  = ($urandom_range(0, 1) == 0);
                step(r_clr, r_ld, r_lt, r_lo, set_lvl, r_inc, r_dec, r_ce, r_ldm);
            end
        end

        idle();
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
